// File: rtl/downsizer_stream.sv
// Width-down converter: splits each IN_BYTES-wide input beat into RATIO
// narrow OUT_BYTES slices, LSB slice first, with valid/ready on both sides.
// With KEEP_EN=1, trailing slices whose keep bits are all zero are not sent.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   in_data/in_keep/in_last    wide beat, per-byte keep, end-of-packet flag
//   in_valid/in_ready          input handshake (in_ready is combinational)
//   out_data/out_keep/out_last narrow slice, slice keep, end-of-packet flag
//   out_valid/out_ready        output handshake
//   busy                       holding register occupied
module downsizer_stream #(
    parameter int unsigned IN_BYTES  = 128,
    parameter int unsigned OUT_BYTES = 32,
    parameter bit          KEEP_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_BYTES*8-1:0]    in_data,
    input  logic [IN_BYTES-1:0]      in_keep,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_BYTES*8-1:0]   out_data,
    output logic [OUT_BYTES-1:0]     out_keep,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int unsigned RATIO = IN_BYTES / OUT_BYTES;
    localparam int unsigned CNT_W = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned IN_W  = IN_BYTES * 8;
    localparam int unsigned OUT_W = OUT_BYTES * 8;

    // Reject ratios that are fractional or below 2 at elaboration.
    generate
        if (((IN_BYTES % OUT_BYTES) != 0) || (RATIO < 2)) begin : g_param_check
            $error("downsizer_stream: IN_BYTES must be a multiple of OUT_BYTES with ratio >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     last_idx_q, last_idx_d;
    logic [IN_W-1:0]      data_q, data_d;
    logic [IN_BYTES-1:0]  keep_q, keep_d;
    logic                 pkt_last_q, pkt_last_d;
    logic [OUT_W-1:0]     out_data_q, out_data_d;
    logic [OUT_BYTES-1:0] out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;

    logic [IN_BYTES-1:0]  keep_eff;
    logic [CNT_W-1:0]     hi_idx;
    logic [CNT_W-1:0]     cnt_inc;
    logic [OUT_W-1:0]     adv_data;
    logic [OUT_BYTES-1:0] adv_keep;
    logic                 final_slice;
    logic                 load;

    // Index of the last slice to emit for the incoming beat; an all-zero
    // keep still yields one slice so the end-of-packet flag is delivered.
    always_comb begin
        keep_eff = KEEP_EN ? in_keep : '1;
        hi_idx   = '0;
        if (KEEP_EN) begin
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (|in_keep[k*OUT_BYTES +: OUT_BYTES]) begin
                    hi_idx = CNT_W'(k);
                end
            end
        end else begin
            hi_idx = CNT_W'(RATIO - 1);
        end
    end

    // Next slice out of the holding register.
    always_comb begin
        cnt_inc  = cnt_q + CNT_W'(1);
        adv_data = '0;
        adv_keep = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt_inc == CNT_W'(k)) begin
                adv_data = data_q[k*OUT_W +: OUT_W];
                adv_keep = keep_q[k*OUT_BYTES +: OUT_BYTES];
            end
        end
    end

    // Final-slice handoff lets a new beat in on the same edge: no bubble.
    assign final_slice = (cnt_q == last_idx_q);
    assign in_ready    = !rst && ((state_q == IDLE) || (out_ready && final_slice));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        data_d     = data_q;
        keep_d     = keep_q;
        pkt_last_d = pkt_last_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (final_slice) begin
                        if (in_valid && in_ready) begin
                            load = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            out_last_d = 1'b0;
                        end
                    end else begin
                        cnt_d      = cnt_inc;
                        out_data_d = adv_data;
                        out_keep_d = adv_keep;
                        out_last_d = pkt_last_q && (cnt_inc == last_idx_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d    = SEND;
            cnt_d      = '0;
            last_idx_d = hi_idx;
            data_d     = in_data;
            keep_d     = keep_eff;
            pkt_last_d = in_last;
            out_data_d = in_data[0 +: OUT_W];
            out_keep_d = keep_eff[0 +: OUT_BYTES];
            out_last_d = in_last && (hi_idx == '0);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_idx_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            out_last_q <= out_last_d;
        end
    end

    // Datapath registers, intentionally not reset.
    always_ff @(posedge clk) begin
        data_q     <= data_d;
        keep_q     <= keep_d;
        pkt_last_q <= pkt_last_d;
        out_data_q <= out_data_d;
        out_keep_q <= out_keep_d;
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_downsizer_stream.sv
// Bench for downsizer_stream (IN_BYTES=16, OUT_BYTES=4): table of beats plus
// hand sequences for backpressure, back-to-back, reset and KEEP_EN=0.
module tb_downsizer_stream;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic [15:0]  in_keep;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic [3:0]   out_keep;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    logic         in0_valid;
    logic         in0_ready;
    logic [31:0]  out0_data;
    logic [3:0]   out0_keep;
    logic         out0_last;
    logic         out0_valid;
    logic         out0_ready;
    logic         busy0;

    downsizer_stream #(.IN_BYTES(16), .OUT_BYTES(4), .KEEP_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    downsizer_stream #(.IN_BYTES(16), .OUT_BYTES(4), .KEEP_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in0_valid), .in_ready(in0_ready),
        .out_data(out0_data), .out_keep(out0_keep), .out_last(out0_last),
        .out_valid(out0_valid), .out_ready(out0_ready), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        fin;
    } slice_t;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        int           n;
    } vec_t;

    slice_t q[$];
    int     checks = 0;
    int     errors = 0;
    int     n_pops = 0;
    int     cyc = 0;
    int     prev_xfer_cyc = -10;
    int     run_len = 0;

    logic        stall_q = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;

    localparam logic [127:0] BASIC = 128'h0F0E0D0C0B0A09080706050403020100;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Reference model: slices expected from one accepted beat.
    function automatic void push_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        int     n;
        slice_t e;
        logic [3:0] ks;
        n = 1;
        for (int s = 0; s < 4; s++) begin
            ks = k[s*4 +: 4];
            if (ks != 4'h0) n = s + 1;
        end
        for (int s = 0; s < n; s++) begin
            e.d   = d[s*32 +: 32];
            e.k   = k[s*4 +: 4];
            e.l   = l && (s == n - 1);
            e.fin = (s == n - 1);
            q.push_back(e);
        end
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: inputs only change just after posedge, so negedge values are
    // the ones seen at the next active edge.
    always @(negedge clk) begin
        slice_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_data", 128'(out_data), 128'(prev_data));
                check("stall_keep", 128'(out_keep), 128'(prev_keep));
                check("stall_last", 128'(out_last), 128'(prev_last));
            end
            if (out_valid && q.size() > 0)
                check("in_ready_busy", 128'(in_ready), 128'(out_ready && q[0].fin));
            else if (!out_valid)
                check("in_ready_idle", 128'(in_ready), 128'(1));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_slice: got data %0h with no slice expected", out_data);
                end else begin
                    e = q.pop_front();
                    check("slice_data", 128'(out_data), 128'(e.d));
                    check("slice_keep", 128'(out_keep), 128'(e.k));
                    check("slice_last", 128'(out_last), 128'(e.l));
                end
                n_pops++;
                run_len = (cyc == prev_xfer_cyc + 1) ? run_len + 1 : 1;
                prev_xfer_cyc = cyc;
            end
            if (in_valid && in_ready) push_beat(in_data, in_keep, in_last);
            stall_q   = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
            prev_last = out_last;
        end
    end

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %0h not accepted within %0d cycles", d, t);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int base, input int exp_n);
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({nm, "_idle"}, 128'(busy), 128'(0));
        check({nm, "_slices"}, 128'(n_pops - base), 128'(exp_n));
        check({nm, "_sb_empty"}, 128'(q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [127:0] rnd;
        logic [127:0] bd;
        int          base;
        int          t;

        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        vecs[0] = '{BASIC, 16'hFFFF, 1'b1, 4};
        vecs[1] = '{BASIC, 16'h003F, 1'b1, 2};
        vecs[2] = '{rnd,   16'h0000, 1'b1, 1};
        vecs[3] = '{rnd,   16'h0F00, 1'b0, 3};
        vecs[4] = '{~rnd,  16'h0001, 1'b1, 1};
        vecs[5] = '{rnd,   16'h8000, 1'b0, 4};
        vecs[6] = '{~rnd,  16'h00F0, 1'b1, 2};

        rst = 1'b1;
        in_data = '0;
        in_keep = '0;
        in_last = 1'b0;
        in_valid = 1'b0;
        in0_valid = 1'b0;
        out_ready = 1'b1;
        out0_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;

        // Table: one beat at a time with out_ready held high.
        for (int i = 0; i < 7; i++) begin
            base = n_pops;
            send_beat(vecs[i].d, vecs[i].k, vecs[i].l);
            check("latency_valid", 128'(out_valid), 128'(1));
            wait_idle("vec", base, vecs[i].n);
            @(posedge clk); #1;
        end

        // Backpressure: 5-cycle stall after slice 0, then toggling ready.
        base = n_pops;
        send_beat(BASIC, 16'hFFFF, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        t = 0;
        while (busy && t < 40) begin
            out_ready = ~out_ready;
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b1;
        wait_idle("bp", base, 4);
        @(posedge clk); #1;

        // Back-to-back: three beats, twelve slices with no bubble.
        base = n_pops;
        send_beat(BASIC, 16'hFFFF, 1'b0);
        send_beat(rnd, 16'hFFFF, 1'b0);
        send_beat(~rnd, 16'hFFFF, 1'b1);
        wait_idle("b2b", base, 12);
        check("b2b_run", 128'(run_len), 128'(12));
        @(posedge clk); #1;

        // Reset after the second slice discards the rest of the beat.
        base = n_pops;
        send_beat(BASIC, 16'hFFFF, 1'b1);
        t = 0;
        while ((n_pops - base) < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("pre_rst_slices", 128'(n_pops - base), 128'(2));
        rst = 1'b1;
        q.delete();
        #1;
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_out_last", 128'(out_last), 128'(0));
        check("mid_rst_in_ready_after", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        check("mid_rst_no_output", 128'(out_valid), 128'(0));
        base = n_pops;
        send_beat(rnd, 16'hFFFF, 1'b1);
        wait_idle("after_rst", base, 4);

        // KEEP_EN=0 instance: no trimming, keep all ones.
        @(posedge clk); #1;
        in_data = BASIC;
        in_keep = 16'h003F;
        in_last = 1'b1;
        in0_valid = 1'b1;
        @(negedge clk);
        check("k0_in_ready", 128'(in0_ready), 128'(1));
        @(posedge clk); #1;
        in0_valid = 1'b0;
        bd = BASIC;
        for (int s = 0; s < 4; s++) begin
            check("k0_valid", 128'(out0_valid), 128'(1));
            check("k0_data", 128'(out0_data), 128'(bd[s*32 +: 32]));
            check("k0_keep", 128'(out0_keep), 128'(4'hF));
            check("k0_last", 128'(out0_last), 128'(s == 3));
            @(posedge clk); #1;
        end
        check("k0_done_valid", 128'(out0_valid), 128'(0));
        check("k0_done_in_ready", 128'(in0_ready), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/downsizer_stream.md
Name: downsizer_stream

Overview:
Parametrised width-down converter for the byte-stream datapath. It splits one wide input beat of IN_BYTES bytes into IN_BYTES/OUT_BYTES narrow output beats. Both sides use full valid/ready backpressure, with per-byte keep and end-of-packet last. Optional keep-aware trimming drops trailing empty slices. It sits between wide internal buses and narrower egress/peripheral ports, and replaces fixed-ratio, no-backpressure splitting.

Parameters:
IN_BYTES, 128, input beat width in bytes
OUT_BYTES, 32, output beat width in bytes; IN_BYTES must be an integer multiple, ratio >= 2 (elaboration error otherwise)
KEEP_EN, 1, 1 = keep-aware trimming of trailing empty slices; 0 = always emit all RATIO slices, out_keep all ones
Derived: RATIO = IN_BYTES/OUT_BYTES; CNT_W = max(1, clog2(RATIO))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  IN_BYTES*8  wide input beat, byte 0 at bits [7:0]
in_keep  input  IN_BYTES  per-byte valid (ignored when KEEP_EN=0)
in_last  input  1  final beat of packet
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input beat
out_data  output  OUT_BYTES*8  narrow output slice
out_keep  output  OUT_BYTES  per-byte valid of slice
out_last  output  1  final slice of packet
out_valid  output  1  output slice valid
out_ready  input  1  downstream accepts slice
busy  output  1  holding register occupied (status)

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, busy=0, slice counter=0, out_last=0. in_ready=0 while rst is high; in_ready=1 from the first cycle after reset. Data/keep registers are not reset. Reset mid-packet discards the held beat with no further output.
- Handshake: a transfer occurs on a clk edge where valid&&ready. Sources must not drop valid before ready. While out_valid&&!out_ready, out_data, out_keep and out_last hold stable.
- Accept: on an input transfer, latch in_data, in_keep and in_last. Compute n_slices:
  - KEEP_EN=1: n_slices = index of the highest slice with any keep bit set, plus 1. If all keep bits are 0, n_slices=1 and that slice is emitted with out_keep=0, so last is never lost.
  - KEEP_EN=0: n_slices = RATIO.
- Latency: first slice has out_valid=1 in the cycle after the input transfer (1-cycle latency). Set busy=1 and counter=0.
- Emit: slice k = bytes [k*OUT_BYTES +: OUT_BYTES], LSB slice first. out_keep = in_keep slice k (KEEP_EN=1) or all ones. out_last = held in_last && (k == n_slices-1). Interior slices always have out_last=0.
- Advance: on an output transfer with k < n_slices-1, k increments.
- Final slice: on the output transfer of the final slice:
  - If in_valid=1 in the same cycle, the new beat is latched and its slice 0 is presented next cycle. No bubble: in_ready = !busy || (out_valid && out_ready && final slice), a combinational path from out_ready.
  - Otherwise busy=0 and out_valid=0.
- Throughput: one output slice per cycle sustained when out_ready=1. Input accepted at most once per n_slices cycles.
- States: IDLE (busy=0, in_ready=1) -> SEND (busy=1) on an input transfer. SEND -> SEND on a non-final output transfer (k+1), or on a final output transfer with a simultaneous input transfer (k=0). SEND -> IDLE on a final output transfer with no input. Stall (out_ready=0) holds all state.
- Counter: CNT_W bits, never exceeds RATIO-1, no wrap-around.

Test Plan:
Bench uses IN_BYTES=16, OUT_BYTES=4, KEEP_EN=1 unless stated.
1. Basic split: one beat, in_data=0x0F0E..0100, keep=0xFFFF, last=1, out_ready=1 -> four slices over 4 consecutive cycles starting 1 cycle later: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, keep=0xF each, out_last only on the 4th.
2. Trimming: keep=0x003F, last=1 -> two slices: keep 0xF then 0x3, out_last on the 2nd. in_ready returns to 1 after 2 slices. Repeat with KEEP_EN=0 -> four slices, keep=0xF, last on the 4th.
3. Backpressure: hold out_ready=0 for 5 cycles mid-packet, then toggle it every cycle -> no slice lost or duplicated, out_data stable during stalls, in_ready=0 throughout.
4. Back-to-back: 3 beats presented continuously, out_ready=1 -> 12 slices in 12 consecutive cycles with no bubble. in_ready pulses high only on the final-slice cycles.
5. Zero keep: keep=0x0000, last=1 -> exactly one slice, out_keep=0, out_last=1.
6. Reset mid-operation: assert rst for 1 cycle after the 2nd slice -> out_valid=0 next cycle, in_ready=0 during rst, then 1. A following beat is split from slice 0.
